// File: rtl/ser10b_pkg.sv
// Shared constants, types and helpers for the 10-bit line serializer.
// Statistics counters are built only when SER10B_STATS_EN is defined.
package ser10b_pkg;

    localparam int WORD_W = 10;
    localparam logic [3:0] LAST_BIT = 4'(WORD_W - 1);

    localparam logic [WORD_W-1:0] K28P5_RDN = 10'b0011111010;
    localparam logic [WORD_W-1:0] K28P5_RDP = 10'b1100000101;

    typedef enum logic {
        RD_NEG = 1'b0,
        RD_POS = 1'b1
    } rd_e;

    typedef enum logic [1:0] {
        LD_DATA   = 2'd0,
        LD_COMMA1 = 2'd1,
        LD_COMMA2 = 2'd2
    } ld_kind_e;

    function automatic logic [3:0] ones_count(input logic [WORD_W-1:0] w);
        logic [3:0] cnt;
        cnt = 4'd0;
        for (int i = 0; i < WORD_W; i++) begin
            cnt = cnt + 4'(w[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/ser10b_rd_track.sv
// Running-disparity legality check and next-RD computation for one
// loaded codeword, based on its ones-count.
module ser10b_rd_track
    import ser10b_pkg::*;
(
    input  logic [WORD_W-1:0] i_word,
    input  rd_e               i_rd,
    output rd_e               o_rd_next,
    output logic              o_illegal
);

    logic [3:0] w_ones;

    assign w_ones = ones_count(i_word);

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        o_rd_next = i_rd;
        o_illegal = 1'b0;
        case (w_ones)
            4'd5: ;
            4'd6: begin
                if (i_rd == RD_NEG) o_rd_next = RD_POS;
                else                o_illegal = 1'b1;
            end
            4'd4: begin
                if (i_rd == RD_POS) o_rd_next = RD_NEG;
                else                o_illegal = 1'b1;
            end
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/ser10b_tx.sv
// Serializer behind the 8B/10B encoder: one codeword per 10-bit slot, K28.5
// idle pairs when starved, RD tracking. Optional counters: SER10B_STATS_EN.
module ser10b_tx
    import ser10b_pkg::*;
#(
    parameter int CNT_W     = 16,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              BITCLK,
    input  logic              RESET_N,
    input  logic [WORD_W-1:0] word_in,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              serial_out,
    output logic              slot_start,
    output logic              idle_active,
    output logic              rd_pos,
    output logic              rd_err,
    output logic [CNT_W-1:0]  idle_cnt,
    output logic [CNT_W-1:0]  err_cnt
);

    logic [3:0]        r_bit_cnt;
    logic [WORD_W-1:0] r_shift;
    logic              r_pair_pend;
    rd_e               r_rd;
    logic              r_serial;
    logic              r_slot_start;
    logic              r_idle;
    logic              r_rd_err;

    logic              w_load;
    logic              w_xfer;
    ld_kind_e          w_kind;
    logic [WORD_W-1:0] w_word;
    logic [WORD_W-1:0] w_line;
    rd_e               w_rd_next;
    logic              w_illegal;

    assign w_load = (r_bit_cnt == LAST_BIT);
    // Gated by RESET_N so the handshake is quiet while the block is held in reset.
    assign word_ready = RESET_N && w_load && !r_pair_pend;
    assign w_xfer     = word_ready && word_valid;

    always_comb begin
        w_kind = LD_DATA;
        w_word = word_in;
        if (r_pair_pend) begin
            w_kind = LD_COMMA2;
            w_word = (r_rd == RD_POS) ? K28P5_RDN : K28P5_RDP;
        end else if (!word_valid) begin
            w_kind = LD_COMMA1;
            w_word = (r_rd == RD_POS) ? K28P5_RDP : K28P5_RDN;
        end
    end

    always_comb begin
        w_line = w_word;
        if (!MSB_FIRST) begin
            for (int i = 0; i < WORD_W; i++) begin
                w_line[i] = w_word[WORD_W-1-i];
            end
        end
    end

    ser10b_rd_track u_rd_track (
        .i_word    (w_word),
        .i_rd      (r_rd),
        .o_rd_next (w_rd_next),
        .o_illegal (w_illegal)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge BITCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_bit_cnt    <= LAST_BIT;
            r_shift      <= '0;
            r_pair_pend  <= 1'b0;
            r_rd         <= RD_NEG;
            r_serial     <= 1'b0;
            r_slot_start <= 1'b0;
            r_idle       <= 1'b0;
            r_rd_err     <= 1'b0;
        end else if (w_load) begin
            r_bit_cnt    <= 4'd0;
            r_serial     <= w_line[WORD_W-1];
            r_shift      <= {w_line[WORD_W-2:0], 1'b0};
            r_slot_start <= 1'b1;
            r_idle       <= (w_kind != LD_DATA);
            r_pair_pend  <= (w_kind == LD_COMMA1);
            r_rd_err     <= w_xfer && w_illegal;
            // Idle commas are disparity-neutral as a pair and never move RD.
            if (w_xfer) r_rd <= w_rd_next;
        end else begin
            r_bit_cnt    <= r_bit_cnt + 4'd1;
            r_serial     <= r_shift[WORD_W-1];
            r_shift      <= {r_shift[WORD_W-2:0], 1'b0};
            r_slot_start <= 1'b0;
            r_rd_err     <= 1'b0;
        end
    end

    assign serial_out  = r_serial;
    assign slot_start  = r_slot_start;
    assign idle_active = r_idle;
    assign rd_pos      = (r_rd == RD_POS);
    assign rd_err      = r_rd_err;

`ifdef SER10B_STATS_EN
    logic [CNT_W-1:0] r_idle_cnt;
    logic [CNT_W-1:0] r_err_cnt;

    always_ff @(posedge BITCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_idle_cnt <= '0;
            r_err_cnt  <= '0;
        end else if (w_load) begin
            if (w_kind == LD_COMMA1 && !(&r_idle_cnt)) r_idle_cnt <= r_idle_cnt + CNT_W'(1);
            if (w_xfer && w_illegal && !(&r_err_cnt))  r_err_cnt  <= r_err_cnt + CNT_W'(1);
        end
    end

    assign idle_cnt = r_idle_cnt;
    assign err_cnt  = r_err_cnt;
`else
    assign idle_cnt = '0;
    assign err_cnt  = '0;
`endif

endmodule
